sram_bus_arbiter: RTL
=====================

SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

Interface
REQ-001 Parameter ADDR_WD, default 64, address width of all ports.
REQ-002 Parameter DATA_WD, default 64, data width; write-strobe width SHALL be DATA_WD/8.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 inst_sram_en / inst_sram_we / inst_sram_addr / inst_sram_wdata  input  1/8/64/64  fetch-port request.
REQ-006 inst_sram_rdata  output  64  fetch-port read data.
REQ-007 data_sram_en / data_sram_we / data_sram_addr / data_sram_wdata  input  1/8/64/64  load/store-port request.
REQ-008 data_sram_rdata  output  64  load/store-port read data.
REQ-009 stallreq_axi  output  1  stall request to pipeline control.
REQ-010 mem_req_valid / mem_req_we / mem_req_addr / mem_req_wdata  output  1/8/64/64  shared memory request channel.
REQ-011 mem_req_ready  input  1  memory accepts request.
REQ-012 mem_resp_valid / mem_resp_rdata  input  1/64  memory response channel.

Function
REQ-013 FSM states SHALL be IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE.
REQ-014 IDLE: data_sram_en=1 -> D_REQ; else inst_sram_en=1 -> I_REQ; else stay. Both pending -> data first, then fetch in the same stall window.
REQ-015 Entering D_REQ/I_REQ SHALL latch the pending-inst flag (inst_sram_en) for the window; port inputs are otherwise sampled live, since the pipeline holds them stable while stalled.
REQ-016 D_REQ/I_REQ: mem_req_valid=1 with the selected port's we/addr/wdata. On mem_req_valid and mem_req_ready -> D_WAIT/I_WAIT. Fields SHALL be stable while valid and not ready.
REQ-017 D_WAIT: mem_resp_valid -> capture mem_resp_rdata into data rdata register. Then I_REQ if the fetch flag is set, else DONE.
REQ-018 I_WAIT: mem_resp_valid -> capture mem_resp_rdata into inst rdata register, then DONE.
REQ-019 DONE: one cycle, then IDLE; no new request is started in DONE.
REQ-020 stallreq_axi SHALL be 1 in D_REQ, D_WAIT, I_REQ and I_WAIT, and also combinationally in IDLE when either en=1. It SHALL be 0 in DONE, and in IDLE with no en.
REQ-021 inst_sram_rdata/data_sram_rdata SHALL be registered, hold their last captured value until the next response for that port, and never be written by the other port's response.
REQ-022 mem_resp_valid in IDLE, D_REQ, I_REQ or DONE SHALL be ignored.
REQ-023 Minimum window SHALL be a single-port access with ready and response each in 1 cycle: IDLE->REQ->WAIT->DONE, stall high 3 cycles.
REQ-024 Writes (we!=0) on the data port SHALL follow the same sequence and capture rdata (value unspecified to the pipeline).

Reset
REQ-025 rst_n=0 SHALL force, asynchronously: state IDLE, fetch flag 0, both rdata registers 0, mem_req_valid 0, and stallreq_axi per REQ-020.
REQ-026 Reset mid-transaction SHALL abandon the access; a response arriving after reset release SHALL be ignored per REQ-022.

Configuration
REQ-027 Macro SRAM_ARB_WR_NORESP_EN defined: a data write whose mem_req_ready handshake completes in D_REQ SHALL skip D_WAIT, go to I_REQ or DONE, and not update data rdata. The memory SHALL then issue no response for writes.
REQ-028 Macro SRAM_ARB_WR_NORESP_EN undefined: writes wait for mem_resp_valid exactly as reads.

Structure
REQ-029 The FSM state encoding, ADDR_WD/DATA_WD defaults and strobe width SHALL live in shared package sram_arb_pkg.
REQ-030 One sub-module, sram_arb_rdata_reg, SHALL implement the per-port captured-rdata register with load enable; it SHALL be instantiated twice. All else is flat.

Verification
REQ-031 Fetch only: inst_sram_en=1, addr=0x8000_0000, ready=1, resp next cycle rdata=0x13 -> stall high 3 cycles, inst_sram_rdata=0x13, data_sram_rdata unchanged.
REQ-032 Both ports: data load addr 0x100 returning 0xAA, fetch addr 0x8000_0004 returning 0xBB -> data request issued first, then fetch; data_sram_rdata=0xAA, inst_sram_rdata=0xBB; stall falls only in DONE.
REQ-033 Backpressure: mem_req_ready=0 for 4 cycles -> mem_req_valid and fields stable, stall high throughout, one handshake only.
REQ-034 Store, we=0xFF, data 0xDEAD -> with SRAM_ARB_WR_NORESP_EN, DONE the cycle after handshake and data_sram_rdata unchanged; without it, the bench waits for mem_resp_valid.
REQ-035 Reset asserted in D_WAIT, then a stray mem_resp_valid after release -> state IDLE, rdata registers 0, stray response ignored.
REQ-036 Spurious mem_resp_valid in IDLE with rdata 0x55 -> no rdata register changes.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM bus arbiter: FSM encoding, default widths
// and the write-strobe width rule.
package sram_arb_pkg;

    function automatic int strb_width(input int data_wd);
        return data_wd / 8;
    endfunction

    localparam int ARB_ADDR_WD = 64;
    localparam int ARB_DATA_WD = 64;
    localparam int ARB_STRB_WD = strb_width(ARB_DATA_WD);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_D_REQ  = 3'd1;
    localparam logic [2:0] S_D_WAIT = 3'd2;
    localparam logic [2:0] S_I_REQ  = 3'd3;
    localparam logic [2:0] S_I_WAIT = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // True while an access is in flight; IDLE stall is added separately.
    function automatic logic is_busy(input logic [2:0] st);
        return (st == S_D_REQ) || (st == S_D_WAIT) || (st == S_I_REQ) || (st == S_I_WAIT);
    endfunction

endpackage

// File: rtl/sram_arb_rdata_reg.sv
// Per-port captured read-data register: loads on a response for its own port,
// otherwise holds its last value.
module sram_arb_rdata_reg
    import sram_arb_pkg::*;
#(
    parameter int DATA_WD = ARB_DATA_WD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DATA_WD-1:0] din,
    output logic [DATA_WD-1:0] dout
);

    logic [DATA_WD-1:0] data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= din;
        end
    end

    assign dout = data_reg;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the fetch and load/store SRAM ports onto one memory request channel,
// data first. Optional macro SRAM_ARB_WR_NORESP_EN: data writes skip the response wait.
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter  int ADDR_WD = ARB_ADDR_WD,
    parameter  int DATA_WD = ARB_DATA_WD,
    localparam int STRB_WD = strb_width(DATA_WD)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inst_sram_en,
    input  logic [STRB_WD-1:0] inst_sram_we,
    input  logic [ADDR_WD-1:0] inst_sram_addr,
    input  logic [DATA_WD-1:0] inst_sram_wdata,
    output logic [DATA_WD-1:0] inst_sram_rdata,
    input  logic               data_sram_en,
    input  logic [STRB_WD-1:0] data_sram_we,
    input  logic [ADDR_WD-1:0] data_sram_addr,
    input  logic [DATA_WD-1:0] data_sram_wdata,
    output logic [DATA_WD-1:0] data_sram_rdata,
    output logic               stallreq_axi,
    output logic               mem_req_valid,
    output logic [STRB_WD-1:0] mem_req_we,
    output logic [ADDR_WD-1:0] mem_req_addr,
    output logic [DATA_WD-1:0] mem_req_wdata,
    input  logic               mem_req_ready,
    input  logic               mem_resp_valid,
    input  logic [DATA_WD-1:0] mem_resp_rdata
);

    logic [2:0] state_reg, state_next;
    logic       inst_pend_reg, inst_pend_next;
    logic       wr_noresp;
    logic       load_data, load_inst;

`ifdef SRAM_ARB_WR_NORESP_EN
    assign wr_noresp = |data_sram_we;
`else
    assign wr_noresp = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        inst_pend_next = inst_pend_reg;
        case (state_reg)
            S_IDLE: begin
                if (data_sram_en)      state_next = S_D_REQ;
                else if (inst_sram_en) state_next = S_I_REQ;
            end
            S_D_REQ: begin
                if (mem_req_ready) begin
                    if (wr_noresp) state_next = inst_pend_reg ? S_I_REQ : S_DONE;
                    else           state_next = S_D_WAIT;
                end
            end
            S_D_WAIT: begin
                if (mem_resp_valid) state_next = inst_pend_reg ? S_I_REQ : S_DONE;
            end
            S_I_REQ: begin
                if (mem_req_ready) state_next = S_I_WAIT;
            end
            S_I_WAIT: begin
                if (mem_resp_valid) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
        // The fetch flag is sampled on every entry into a request state.
        if ((state_next != state_reg) && ((state_next == S_D_REQ) || (state_next == S_I_REQ))) begin
            inst_pend_next = inst_sram_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            inst_pend_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            inst_pend_reg <= inst_pend_next;
        end
    end

    // Request fields come straight from the held port inputs, so they stay stable under backpressure.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_we    = '0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        if (state_reg == S_D_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_we    = data_sram_we;
            mem_req_addr  = data_sram_addr;
            mem_req_wdata = data_sram_wdata;
        end else if (state_reg == S_I_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_we    = inst_sram_we;
            mem_req_addr  = inst_sram_addr;
            mem_req_wdata = inst_sram_wdata;
        end
    end

    assign stallreq_axi = is_busy(state_reg) ||
                          ((state_reg == S_IDLE) && (data_sram_en || inst_sram_en));

    assign load_data = (state_reg == S_D_WAIT) && mem_resp_valid;
    assign load_inst = (state_reg == S_I_WAIT) && mem_resp_valid;

    sram_arb_rdata_reg #(.DATA_WD(DATA_WD)) u_data_rdata (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_data),
        .din   (mem_resp_rdata),
        .dout  (data_sram_rdata)
    );

    sram_arb_rdata_reg #(.DATA_WD(DATA_WD)) u_inst_rdata (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_inst),
        .din   (mem_resp_rdata),
        .dout  (inst_sram_rdata)
    );

endmodule
